// File: rtl/sdram_sched_pkg.sv
// sdram_sched_pkg: shared types and constants for the SDRAM port scheduler
package sdram_sched_pkg;
  typedef enum logic [1:0] {LOAD, DRAIN, NES} state_t;
  localparam logic [1:0] SLOT_PHASE = 2'd3;
  localparam int LD_ADDR_W = 22;
  typedef struct packed {
    logic [LD_ADDR_W-1:0] addr;
    logic [7:0]           data;
  } ld_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with combinational head and exact occupancy
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full    = level == LW'(DEPTH);
  assign empty   = level == '0;
  assign dout    = mem[rd_ptr];
  // pointer and occupancy bookkeeping; a push while full only lands if a pop frees the slot
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end
  // storage array, written only on accepted pushes
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/sdram_port_scheduler.sv
// sdram_port_scheduler: time-shares the SDRAM user port between loader writes and the NES core
module sdram_port_scheduler
  import sdram_sched_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = LD_ADDR_W,
  parameter int CNT_W      = 22
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [1:0]                    ce_phase,
  input  logic                          load_done,
  input  logic                          flush,
  input  logic                          ld_valid,
  input  logic [ADDR_W-1:0]             ld_addr,
  input  logic [7:0]                    ld_data,
  input  logic [ADDR_W-1:0]             nes_addr,
  input  logic                          nes_read_cpu,
  input  logic                          nes_read_ppu,
  input  logic                          nes_write,
  input  logic [7:0]                    nes_dout,
  output logic [ADDR_W+2:0]             sd_addr,
  output logic                          sd_we,
  output logic [7:0]                    sd_din,
  output logic                          sd_oeA,
  output logic                          sd_oeB,
  output logic                          sd_dq_oe,
  output logic                          nes_hold,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [CNT_W-1:0]              write_count
);
  state_t    state, state_n;
  ld_entry_t head, slot;
  logic      slot_we, slot_edge, push, pop, full, empty, nes_mode;
  assign nes_mode  = state == NES;
  assign slot_edge = ce_phase == SLOT_PHASE;
  assign push      = ld_valid & ~nes_mode & ~flush;
  assign pop       = slot_edge & ~nes_mode & ~flush;
  sync_fifo #(.W($bits(ld_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .resetn(resetn),
    .clr   (flush),
    .push  (push),
    .pop   (pop),
    .din   ({ld_addr, ld_data}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );
  // mode register; nes_hold drops only once NES has been held for a full clk
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= LOAD;
      nes_hold <= 1'b1;
    end else begin
      state    <= state_n;
      nes_hold <= !(nes_mode && state_n == NES);
    end
  end
  // next mode plus port mux: NES is a zero-latency pass-through, otherwise the slot register drives
  always_comb begin
    state_n  = flush ? LOAD :
               nes_mode ? (load_done ? NES : LOAD) :
               !load_done ? LOAD :
               (slot_edge && empty && !ld_valid) ? NES : DRAIN;
    sd_addr  = nes_mode ? {3'b0, nes_addr} : {3'b0, slot.addr};
    sd_we    = nes_mode ? nes_write : slot_we;
    sd_din   = nes_mode ? nes_dout : slot.data;
    sd_oeA   = nes_mode & nes_read_cpu;
    sd_oeB   = nes_mode & nes_read_ppu;
    sd_dq_oe = sd_we;
  end
  // slot register reloads at each phase-3 edge and holds for the following four clks
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      slot_we <= 1'b0;
      slot    <= '0;
    end else if (flush || nes_mode) begin
      slot_we <= 1'b0;
    end else if (slot_edge) begin
      slot_we <= !empty;
      slot    <= empty ? slot : head;
    end
  end
  // status: sticky drop flag and committed-write counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overflow    <= 1'b0;
      write_count <= '0;
    end else if (flush) begin
      overflow    <= 1'b0;
      write_count <= '0;
    end else begin
      overflow    <= overflow | (push & full & ~pop);
      write_count <= write_count + CNT_W'(pop & ~empty);
    end
  end
endmodule
